// File: rtl/seg7_rx_monitor.sv
// Receive-side monitor for an active-low seven-segment bus: stability filter,
// hex decode and mod-10 sequence tracking. Define SEG7MON_ERRCNT_EN to build the error counter.
`timescale 1ns/1ps

module seg7_rx_monitor #(
  parameter int STABLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       hin,
  input  logic             sample_en,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             illegal,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic       ST_SYNC  = 1'b0;
  localparam logic       ST_TRACK = 1'b1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] STABLE    = 4'(STABLE_CYC);

  // Returns {legal, value}; blank and unknown patterns both report legal=0.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40: decode = {1'b1, 4'h0};
      7'h79: decode = {1'b1, 4'h1};
      7'h24: decode = {1'b1, 4'h2};
      7'h30: decode = {1'b1, 4'h3};
      7'h19: decode = {1'b1, 4'h4};
      7'h12: decode = {1'b1, 4'h5};
      7'h02: decode = {1'b1, 4'h6};
      7'h78: decode = {1'b1, 4'h7};
      7'h00: decode = {1'b1, 4'h8};
      7'h10: decode = {1'b1, 4'h9};
      7'h08: decode = {1'b1, 4'hA};
      7'h03: decode = {1'b1, 4'hB};
      7'h46: decode = {1'b1, 4'hC};
      7'h21: decode = {1'b1, 4'hD};
      7'h06: decode = {1'b1, 4'hE};
      7'h0E: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  logic [6:0] hin_q, hin_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] stab_q, stab_d;
  logic       state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] digit_q, digit_d;
  logic       dv_q, dv_d;
  logic       ill_q, ill_d;
  logic       seq_q, seq_d;
  logic       reload;
  logic       accept;
  logic       dec_legal;
  logic [3:0] dec_val;

  assign hin_d = hin;
  assign {dec_legal, dec_val} = decode(cand_d);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    state_d = state_q;
    exp_d   = exp_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    reload  = 1'b0;
    accept  = 1'b0;

    if (sample_en) begin
      reload = (hin_q != cand_q);
      if (reload) begin
        cand_d = hin_q;
        stab_d = 4'd1;
      end else if (stab_q != STABLE) begin
        stab_d = stab_q + 4'd1;
      end
      // A reload also counts as reaching the threshold when STABLE_CYC is 1.
      accept = (stab_d == STABLE) && (reload || (stab_q != STABLE));
    end

    if (accept) begin
      if (cand_d == SEG_BLANK) begin
        if (state_q == ST_TRACK) state_d = ST_SYNC;
      end else if (dec_legal) begin
        digit_d = dec_val;
        dv_d    = 1'b1;
        if (dec_val <= 4'd9) begin
          if ((state_q == ST_TRACK) && (dec_val != exp_q)) seq_d = 1'b1;
          state_d = ST_TRACK;
          exp_d   = (dec_val == 4'd9) ? 4'd0 : dec_val + 4'd1;
        end else if (state_q == ST_TRACK) begin
          seq_d   = 1'b1;
          state_d = ST_SYNC;
        end
      end else begin
        ill_d = 1'b1;
        if (state_q == ST_TRACK) begin
          seq_d   = 1'b1;
          state_d = ST_SYNC;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hin_q   <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      stab_q  <= 4'd0;
      state_q <= ST_SYNC;
      exp_q   <= 4'd0;
      digit_q <= 4'd0;
      dv_q    <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      hin_q   <= hin_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      exp_q   <= exp_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign illegal     = ill_q;
  assign seq_err     = seq_q;
  assign locked      = (state_q == ST_TRACK);

`ifdef SEG7MON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_ev;

  // Coinciding conditions on one acceptance still collapse into a single event.
  always_comb begin
    err_ev    = seq_d || ill_d || (dv_d && (digit_d > 4'd9) && (state_q == ST_SYNC));
    err_cnt_d = err_cnt_q;
    if (err_ev && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
